// File: rtl/lvt_write_arbiter_if.sv
// rtl/lvt_write_arbiter_if.sv - request streams and RAM write-port bundle for lvt_write_arbiter
interface lvt_write_arbiter_if #(
  parameter int BLOCKSIZE = 10
);
  logic                 in1_valid;
  logic                 in1_ready;
  logic [BLOCKSIZE:0]   in1_addr;
  logic [31:0]          in1_data;
  logic                 in2_valid;
  logic                 in2_ready;
  logic [BLOCKSIZE:0]   in2_addr;
  logic [31:0]          in2_data;
  logic [BLOCKSIZE:0]   w_addr_1;
  logic [31:0]          w_din_1;
  logic                 w_enb_1;
  logic [BLOCKSIZE:0]   w_addr_2;
  logic [31:0]          w_din_2;
  logic                 w_enb_2;

  modport master (
    output in1_valid, in1_addr, in1_data, in2_valid, in2_addr, in2_data,
    input  in1_ready, in2_ready,
    input  w_addr_1, w_din_1, w_enb_1, w_addr_2, w_din_2, w_enb_2
  );

  modport slave (
    input  in1_valid, in1_addr, in1_data, in2_valid, in2_addr, in2_data,
    output in1_ready, in2_ready,
    output w_addr_1, w_din_1, w_enb_1, w_addr_2, w_din_2, w_enb_2
  );
endinterface

// File: rtl/lvt_write_arbiter.sv
// rtl/lvt_write_arbiter.sv - dual write-stream FIFO front end with same-address collision serialising
// Optional LVT_ARB_COALESCE_EN: a collision pops both heads and only port 2's write is issued.
module lvt_write_arbiter #(
  parameter int BLOCKSIZE  = 10,
  parameter int DEPTH_LOG2 = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  lvt_write_arbiter_if.slave bus,
  output logic [CNT_W-1:0]  conflict_cnt,
  output logic              idle
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef logic [DEPTH_LOG2:0] ptr_t;

  ptr_t               wr_ptr    [2];
  ptr_t               rd_ptr    [2];
  ptr_t               wr_nxt    [2];
  ptr_t               rd_nxt    [2];
  logic [BLOCKSIZE:0] mem_addr  [2][DEPTH];
  logic [31:0]        mem_data  [2][DEPTH];
  logic [BLOCKSIZE:0] in_addr   [2];
  logic [31:0]        in_data   [2];
  logic [BLOCKSIZE:0] head_addr [2];
  logic [31:0]        head_data [2];
  logic [1:0]         push, pop, issue, empty, empty_nxt, full_nxt, rdy_q;
  logic               conflict, pri, pri_nxt;

  assign bus.in1_ready = rdy_q[0];
  assign bus.in2_ready = rdy_q[1];

  always_comb begin
    in_addr[0] = bus.in1_addr;
    in_data[0] = bus.in1_data;
    in_addr[1] = bus.in2_addr;
    in_data[1] = bus.in2_data;
    push       = {bus.in2_valid & rdy_q[1], bus.in1_valid & rdy_q[0]};
    for (int i = 0; i < 2; i++) begin
      empty[i]     = (wr_ptr[i] == rd_ptr[i]);
      head_addr[i] = mem_addr[i][rd_ptr[i][DEPTH_LOG2-1:0]];
      head_data[i] = mem_data[i][rd_ptr[i][DEPTH_LOG2-1:0]];
    end

    conflict = !empty[0] && !empty[1] && (head_addr[0] == head_addr[1]);
    issue    = ~empty;
    pop      = ~empty;
    pri_nxt  = pri;
    if (conflict) begin
`ifdef LVT_ARB_COALESCE_EN
      issue = 2'b10;
      pop   = 2'b11;
`else
      issue   = pri ? 2'b10 : 2'b01;
      pop     = issue;
      pri_nxt = !pri;
`endif
    end

    // Full when the pointers differ only in their wrap bit.
    for (int i = 0; i < 2; i++) begin
      wr_nxt[i]    = wr_ptr[i] + ptr_t'(push[i]);
      rd_nxt[i]    = rd_ptr[i] + ptr_t'(pop[i]);
      empty_nxt[i] = (wr_nxt[i] == rd_nxt[i]);
      full_nxt[i]  = ((wr_nxt[i] ^ rd_nxt[i]) == ptr_t'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) begin
        mem_addr[i][wr_ptr[i][DEPTH_LOG2-1:0]] <= in_addr[i];
        mem_data[i][wr_ptr[i][DEPTH_LOG2-1:0]] <= in_data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      rdy_q        <= '0;
      pri          <= 1'b0;
      bus.w_enb_1  <= 1'b0;
      bus.w_addr_1 <= '0;
      bus.w_din_1  <= '0;
      bus.w_enb_2  <= 1'b0;
      bus.w_addr_2 <= '0;
      bus.w_din_2  <= '0;
      conflict_cnt <= '0;
      idle         <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= wr_nxt[i];
        rd_ptr[i] <= rd_nxt[i];
      end
      rdy_q       <= ~full_nxt;
      pri         <= pri_nxt;
      bus.w_enb_1 <= issue[0];
      bus.w_enb_2 <= issue[1];
      if (issue[0]) begin
        bus.w_addr_1 <= head_addr[0];
        bus.w_din_1  <= head_data[0];
      end
      if (issue[1]) begin
        bus.w_addr_2 <= head_addr[1];
        bus.w_din_2  <= head_data[1];
      end
      if (conflict && (conflict_cnt != {CNT_W{1'b1}}))
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      idle <= (&empty_nxt) && !(|issue);
    end
  end
endmodule

// File: tb/tb_lvt_write_arbiter.sv
// tb/tb_lvt_write_arbiter.sv - self-checking bench for lvt_write_arbiter (table, corner sequences, random vs queue model)
module tb_lvt_write_arbiter;
  localparam int BS    = 10;
  localparam int DL    = 2;
  localparam int CW    = 16;
  localparam int DEPTH = 1 << DL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lvt_write_arbiter_if #(.BLOCKSIZE(BS)) bus ();
  logic [CW-1:0] conflict_cnt;
  logic          idle;

  lvt_write_arbiter #(.BLOCKSIZE(BS), .DEPTH_LOG2(DL), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .conflict_cnt (conflict_cnt),
    .idle         (idle)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [BS:0] a;
    logic [31:0] d;
  } req_t;

  req_t        q1[$], q2[$];
  bit          m_pri;
  int          m_cnt;
  logic        m_enb1, m_enb2, m_rdy1, m_rdy2, m_idle;
  logic [BS:0] m_a1, m_a2;
  logic [31:0] m_d1, m_d2;
  logic [31:0] iss1[$];

  // Queue-level reference: heads decide this edge's writes, then accepted requests join the tails.
  task automatic model_step(input bit r, input bit v1, input int a1, input logic [31:0] d1,
                            input bit v2, input int a2, input logic [31:0] d2);
    bit   acc1, acc2;
    req_t h;
    if (r) begin
      q1.delete(); q2.delete();
      m_pri = 0; m_cnt = 0;
      m_enb1 = 0; m_enb2 = 0; m_a1 = '0; m_a2 = '0; m_d1 = '0; m_d2 = '0;
      m_rdy1 = 0; m_rdy2 = 0; m_idle = 1;
      return;
    end
    acc1 = v1 && m_rdy1;
    acc2 = v2 && m_rdy2;
    m_enb1 = 0;
    m_enb2 = 0;
    if (q1.size() > 0 && q2.size() > 0 && q1[0].a == q2[0].a) begin
      if (m_cnt < (1 << CW) - 1) m_cnt++;
`ifdef LVT_ARB_COALESCE_EN
      h = q2.pop_front(); void'(q1.pop_front());
      m_enb2 = 1; m_a2 = h.a; m_d2 = h.d;
`else
      if (!m_pri) begin
        h = q1.pop_front(); m_enb1 = 1; m_a1 = h.a; m_d1 = h.d;
      end else begin
        h = q2.pop_front(); m_enb2 = 1; m_a2 = h.a; m_d2 = h.d;
      end
      m_pri = !m_pri;
`endif
    end else begin
      if (q1.size() > 0) begin h = q1.pop_front(); m_enb1 = 1; m_a1 = h.a; m_d1 = h.d; end
      if (q2.size() > 0) begin h = q2.pop_front(); m_enb2 = 1; m_a2 = h.a; m_d2 = h.d; end
    end
    if (acc1) q1.push_back({a1[BS:0], d1});
    if (acc2) q2.push_back({a2[BS:0], d2});
    m_rdy1 = (q1.size() < DEPTH);
    m_rdy2 = (q2.size() < DEPTH);
    m_idle = (q1.size() == 0) && (q2.size() == 0) && !m_enb1 && !m_enb2;
  endtask

  // Drive at the falling edge, clock once, compare everything at the next falling edge.
  task automatic cycle(input bit r, input bit v1, input int a1, input logic [31:0] d1,
                       input bit v2, input int a2, input logic [31:0] d2);
    rst = r;
    bus.in1_valid = v1; bus.in1_addr = a1[BS:0]; bus.in1_data = d1;
    bus.in2_valid = v2; bus.in2_addr = a2[BS:0]; bus.in2_data = d2;
    model_step(r, v1, a1, d1, v2, a2, d2);
    @(posedge clk);
    @(negedge clk);
    if (bus.w_enb_1) iss1.push_back(bus.w_din_1);
    check("w_enb_1", bus.w_enb_1, m_enb1);
    check("w_enb_2", bus.w_enb_2, m_enb2);
    check("w_addr_1", bus.w_addr_1, m_a1);
    check("w_din_1", bus.w_din_1, m_d1);
    check("w_addr_2", bus.w_addr_2, m_a2);
    check("w_din_2", bus.w_din_2, m_d2);
    check("in1_ready", bus.in1_ready, m_rdy1);
    check("in2_ready", bus.in2_ready, m_rdy2);
    check("conflict_cnt", conflict_cnt, m_cnt);
    check("idle", idle, m_idle);
  endtask

  task automatic idle_cycle();
    cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit          r, v1;  int a1; logic [31:0] d1;
    bit          v2;     int a2; logic [31:0] d2;
    bit          e1;     int ea1; logic [31:0] ed1;
    bit          e2;     int ea2; logic [31:0] ed2;
    int          ecnt;
    bit          eidle, erdy1;
  } vec_t;

  localparam logic [31:0] DA  = 32'hAAAA0001;
  localparam logic [31:0] DB  = 32'hBBBB0002;
  localparam logic [31:0] DA2 = 32'hAAAA0003;
  localparam logic [31:0] DB2 = 32'hBBBB0004;
  localparam logic [31:0] DC  = 32'hCCCC0005;

  vec_t tbl[11];

  initial begin
    int   pat[$];
    int   idx, refused, cnt8;
    bit   got, was_rdy;
    logic [31:0] rd1, rd2;

    bus.in1_valid = 0; bus.in1_addr = '0; bus.in1_data = '0;
    bus.in2_valid = 0; bus.in2_addr = '0; bus.in2_data = '0;
    @(negedge clk);

    //            r v1 a1 d1   v2 a2 d2   e1 ea1 ed1  e2 ea2 ed2  cnt idle rdy1
    tbl[0]  = '{1, 1, 0, 0,   0, 0, 0,   0, 0, 0,    0, 0, 0,    0,  1,   0};
    tbl[1]  = '{1, 1, 0, 0,   0, 0, 0,   0, 0, 0,    0, 0, 0,    0,  1,   0};
    tbl[2]  = '{1, 1, 0, 0,   0, 0, 0,   0, 0, 0,    0, 0, 0,    0,  1,   0};
    tbl[3]  = '{0, 0, 0, 0,   0, 0, 0,   0, 0, 0,    0, 0, 0,    0,  1,   1};
    tbl[4]  = '{0, 1, 5, DA,  1, 9, DB,  0, 0, 0,    0, 0, 0,    0,  0,   1};
    tbl[5]  = '{0, 0, 0, 0,   0, 0, 0,   1, 5, DA,   1, 9, DB,   0,  0,   1};
    tbl[6]  = '{0, 0, 0, 0,   0, 0, 0,   0, 5, DA,   0, 9, DB,   0,  1,   1};
    tbl[7]  = '{0, 1, 7, DA2, 1, 7, DB2, 0, 5, DA,   0, 9, DB,   0,  0,   1};
`ifdef LVT_ARB_COALESCE_EN
    tbl[8]  = '{0, 0, 0, 0,   0, 0, 0,   0, 5, DA,   1, 7, DB2,  1,  0,   1};
    tbl[9]  = '{0, 0, 0, 0,   0, 0, 0,   0, 5, DA,   0, 7, DB2,  1,  1,   1};
    tbl[10] = '{0, 0, 0, 0,   0, 0, 0,   0, 5, DA,   0, 7, DB2,  1,  1,   1};
`else
    tbl[8]  = '{0, 0, 0, 0,   0, 0, 0,   1, 7, DA2,  0, 9, DB,   1,  0,   1};
    tbl[9]  = '{0, 0, 0, 0,   0, 0, 0,   0, 7, DA2,  1, 7, DB2,  1,  0,   1};
    tbl[10] = '{0, 0, 0, 0,   0, 0, 0,   0, 7, DA2,  0, 7, DB2,  1,  1,   1};
`endif

    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].r, tbl[i].v1, tbl[i].a1, tbl[i].d1, tbl[i].v2, tbl[i].a2, tbl[i].d2);
      check($sformatf("tbl%0d_enb_1", i), bus.w_enb_1, tbl[i].e1);
      check($sformatf("tbl%0d_addr_1", i), bus.w_addr_1, tbl[i].ea1);
      check($sformatf("tbl%0d_din_1", i), bus.w_din_1, tbl[i].ed1);
      check($sformatf("tbl%0d_enb_2", i), bus.w_enb_2, tbl[i].e2);
      check($sformatf("tbl%0d_addr_2", i), bus.w_addr_2, tbl[i].ea2);
      check($sformatf("tbl%0d_din_2", i), bus.w_din_2, tbl[i].ed2);
      check($sformatf("tbl%0d_cnt", i), conflict_cnt, tbl[i].ecnt);
      check($sformatf("tbl%0d_idle", i), idle, tbl[i].eidle);
      check($sformatf("tbl%0d_in1_ready", i), bus.in1_ready, tbl[i].erdy1);
    end

    // Fairness: both ports hammer address 12.
    cycle(1, 0, 0, 0, 0, 0, 0);
    got = 0; cnt8 = 0;
    for (int i = 0; i < 14; i++) begin
      if (i < 8) cycle(0, 1, 12, 32'h100 + i, 1, 12, 32'h200 + i);
      else       idle_cycle();
      if (bus.w_enb_1) pat.push_back(1);
      if (bus.w_enb_2) pat.push_back(2);
      if (pat.size() >= 8 && !got) begin got = 1; cnt8 = conflict_cnt; end
    end
    check("fair_reached_8", got, 1);
    check("fair_cnt_at_8", cnt8, 8);
    for (int i = 0; i < 8 && i < pat.size(); i++) begin
`ifdef LVT_ARB_COALESCE_EN
      check($sformatf("fair_port_%0d", i), pat[i], 2);
`else
      check($sformatf("fair_port_%0d", i), pat[i], (i % 2) ? 2 : 1);
`endif
    end

    // Fill and wrap on port 1: 14 items, retried until accepted.
    cycle(1, 0, 0, 0, 0, 0, 0);
    iss1.delete();
    idx = 0; refused = 0;
    for (int c = 0; c < 200 && idx < 14; c++) begin
      was_rdy = bus.in1_ready;
`ifdef LVT_ARB_COALESCE_EN
      cycle(0, 1, 20, 32'h300 + idx, 0, 0, 0);
`else
      cycle(0, 1, 20, 32'h300 + idx, 1, 20, 32'h400 + c);
`endif
      if (was_rdy) idx++;
      else refused++;
    end
    check("fill_all_accepted", idx, 14);
`ifndef LVT_ARB_COALESCE_EN
    check("fill_push_refused", refused > 0, 1);
`endif
    for (int c = 0; c < 40; c++) idle_cycle();
    check("fill_issue_count", iss1.size(), 14);
    for (int i = 0; i < 14 && i < iss1.size(); i++)
      check($sformatf("fill_order_%0d", i), iss1[i], 32'h300 + i);

    // Mid-operation reset with queued writes.
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 40 + i, 32'h500 + i, 1, 50 + i, 32'h600 + i);
    cycle(1, 0, 0, 0, 0, 0, 0);
    rd1 = bus.w_enb_1; rd2 = bus.w_enb_2;
    check("mrst_enb_during", {rd1[0], rd2[0]}, 0);
    for (int i = 0; i < 4; i++) begin
      idle_cycle();
      check($sformatf("mrst_quiet_%0d", i), {bus.w_enb_1, bus.w_enb_2}, 0);
      check($sformatf("mrst_idle_%0d", i), idle, 1);
    end
    cycle(0, 0, 0, 0, 1, 3, DC);
    check("mrst_new_not_yet", bus.w_enb_2, 0);
    idle_cycle();
    check("mrst_new_enb_2", bus.w_enb_2, 1);
    check("mrst_new_addr_2", bus.w_addr_2, 3);
    check("mrst_new_din_2", bus.w_din_2, DC);

    // Random traffic over a narrow address range to provoke collisions.
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 59) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom);
    end
    for (int i = 0; i < 12; i++) idle_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
